// File: rtl/seq_mult_engine.sv
// Shift-add unsigned multiplier: one multiplier bit per clock, product registered on completion.
// Latency: WIDTH cycles from the accepting start edge to done=1 with product valid.
// Backpressure: start is ignored while busy; product/done hold until the next completion.
module seq_mult_engine #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;

    // Carry of the add lands in acc[WIDTH] and is shifted down into the product.
    assign sum     = acc + (mplier[0] ? {1'b0, mcand} : '0);
    assign shifted = {sum, mplier} >> 1;

    assign busy = (state == CALC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        done   <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= shifted[2*WIDTH:WIDTH];
                    mplier <= shifted[WIDTH-1:0];
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        product <= shifted[2*WIDTH-1:0];
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_mult_engine.md
# seq_mult_engine

Sequential shift-add unsigned multiplier: the arithmetic engine driven by the iteration controller's `eng_start` / `eng_done` handshake. Captures two operands on a start pulse, computes their product in exactly WIDTH clock cycles (one multiplier bit per cycle), then publishes the result and raises a level `done` that the controller polls while waiting. The product register holds the last result stable until the next completion, so the controller's result-write can occur any time after `done`.

## Interface
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled on rising edge, honoured only when not busy.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- product  output  2*WIDTH  registered result of the last completed operation.
- done  output  1  level; high when a result is valid and no operation is in progress.
- busy  output  1  level; high while iterating.

## Operation
- Unsigned operands only; the full 2*WIDTH-bit product never overflows.
- States:
  - IDLE
  - CALC
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - product=0, done=0, busy=0.
  - Internal accumulator, multiplier shadow and counter are cleared.
- IDLE, start=1 at an edge:
  - Latch a into the multiplicand register and b into the multiplier shift register.
  - Clear the (WIDTH+1)-bit upper accumulator; counter=0.
  - done<=0, busy<=1, state<=CALC.
- IDLE, start=0: hold everything; done keeps its value.
- CALC, each edge:
  - If multiplier LSB=1, add the multiplicand to the upper accumulator (carry kept in bit WIDTH).
  - Shift {accumulator, multiplier} right by one; counter<=counter+1.
- CALC, on the edge where counter==WIDTH-1 (last iteration):
  - Load product with the post-shift {accumulator, multiplier} low 2*WIDTH bits.
  - done<=1, busy<=0, state<=IDLE.
- start during CALC is ignored: no restart, no operand recapture.
- a and b may change freely after the accepting edge.
- Counter width is clog2(WIDTH)+1 so WIDTH-1 is always representable.
- done and busy are never both 1. Both are 0 only after reset, before the first operation.

## Timing
- Start accepted at edge k.
- busy=1 and done=0 visible after edge k.
- Iterations occur at edges k+1 … k+WIDTH.
- product valid, done=1, busy=0 after edge k+WIDTH. Latency is WIDTH cycles from the accepting edge (8 for the default).
- done is cleared by the accepting edge itself. A controller that pulses start for one cycle and then polls done never sees a stale done from the previous operation.
- Back-to-back: start=1 on the same cycle done=1 (IDLE) is accepted. done falls after that edge, and product keeps the old value until the new completion.
- product changes only on completion edges or reset, never mid-operation.
- Reset mid-CALC aborts immediately and asynchronously to the reset values.
- After rst deassertion the block is in IDLE and accepts start on the first rising edge.

## Test plan
- Reset, then a=13, b=11, 1-cycle start:
  - busy=1 for 8 cycles.
  - After the 8th edge: product=143, done=1, busy=0.
- a=255, b=255 → product=65025 (0xFE01) after 8 cycles; exercises the accumulator carry bit.
- a=0, b=200, then a=200, b=0 → product=0 each time; done asserts after exactly 8 cycles regardless of operand values.
- Start with a=7, b=9:
  - Pulse start again at cycle 3 with a=100, b=100.
  - Required: second start ignored; product=63 at cycle 8.
  - Changing a and b after the accepting edge does not affect the result.
- Complete 6×5=30, then start 3×4 on the cycle done=1:
  - done=0 the next cycle.
  - product stays 30 through the computation, becomes 12 after 8 cycles.
- Start 200×3, assert rst=0 mid-cycle at iteration 4:
  - product=0, done=0, busy=0 immediately, without waiting for a clock edge.
  - After release, 2×2 yields product=4 after 8 cycles.
